click_demux_n: RTL and testbench
================================

Name: click_demux_n

Overview:
- Clocked, parametrised N-way successor to the two-way click demux.
- Accepts one two-phase bundled-data token from the input channel together with a select token, and routes it to exactly one of N two-phase output channels.
- Output data is registered, not pass-through.
- Bridges click-style handshake networks into the synchronous domain; out-of-range selects are detected and counted.

Parameters:
- N_OUT, 4, number of output channels (2..16)
- DATA_W, 8, data width per channel
- SEL_W, $clog2(N_OUT), select bus width (derived; not overridden)
- PHASE_INIT_A, 0, reset phase of in_ack/sel_ack
- PHASE_INIT_OUT, '0, N_OUT-bit reset phase vector of out_req (bit k = channel k)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_req  in  1  input channel two-phase request
- in_ack  out  1  input channel ack (shared phase with sel_ack)
- in_data  in  DATA_W  input bundled data
- sel_req  in  1  select channel two-phase request
- sel_ack  out  1  select ack (equals in_ack)
- sel_data  in  SEL_W  output channel index
- out_req  out  N_OUT  per-channel two-phase request
- out_ack  in  N_OUT  per-channel two-phase ack
- out_data  out  N_OUT*DATA_W  per-channel registered data, channel k at [k*DATA_W +: DATA_W]
- sel_err  out  1  sticky: out-of-range select seen
- drop_cnt  out  8  count of dropped (out-of-range) tokens, saturating

Behaviour:
- Single clock; reset synchronous, active-high; all state updates on posedge clk.
- Reset values:
  - in_ack = sel_ack = PHASE_INIT_A
  - out_req = PHASE_INIT_OUT
  - out_data = 0
  - sel_err = 0, drop_cnt = 0
  - state = IDLE
- Token pending: (in_req != in_ack) && (sel_req != in_ack).
- Channel k idle: out_ack[k] == out_req[k].
- States:
  - IDLE: if token pending, all channels idle, and sel_data < N_OUT: latch in_data into out_data[k=sel_data], toggle out_req[k], store k, go to WAIT. Latch and toggle are on the same edge, so data is stable before the req edge.
  - IDLE: if token pending and sel_data >= N_OUT: toggle in_ack (drop token), set sel_err, drop_cnt += 1 (saturate at 255), stay IDLE.
  - WAIT: when out_ack[k] == out_req[k], toggle in_ack, go to IDLE. Other channels' out_data/out_req are untouched.
- Latency:
  - out_req edge 1 cycle after the pending condition is sampled.
  - in_ack edge 1 cycle after the matching out_ack is sampled.
  - Minimum 2 cycles per token; next token accepted no earlier than the cycle after in_ack toggles.
- Only one token in flight; no reordering.
- Pending token while any channel is not idle (e.g. ack from a previous reset phase mismatch): hold in IDLE, no toggles.
- in_data and sel_data must be stable from req edge until in_ack toggles (bundled-data constraint on the sender).
- Simultaneous rst and pending token: reset wins; token is not consumed.
- Reset during WAIT: return to IDLE, phases reinitialised; the in-flight output handshake is abandoned (the environment is reset too).
- Unused out_ack toggles on non-selected channels are ignored in WAIT, but block acceptance in IDLE.

Optional Feature:
- CLICK_DEMUX_SYNC_EN defined: two-flop synchronisers on in_req, sel_req and each out_ack bit. All decisions use the synchronised values. Latency +2 cycles on each direction. in_data/sel_data are sampled only after the synchronised req indicates pending. Synchronisers reset to the matching reset phase so no spurious token appears after reset.
- Not defined: inputs assumed synchronous to clk; no extra flops; latency as above.

Test Plan:
- Reset with PHASE_INIT_A=0, PHASE_INIT_OUT=4'b0000 -> in_ack=0, out_req=0000, out_data=0, sel_err=0, drop_cnt=0.
- in_data=8'hA5, sel_data=2, toggle in_req and sel_req to 1 -> next cycle out_req=0100, out_data[2]=A5; hold out_ack[2]; toggle out_ack[2]=1 -> one cycle later in_ack=1.
- Four tokens 11,22,33,44 to channels 0,1,2,3 with immediate acks -> each channel toggles once with correct data, out_req=1111, in_ack toggled 4 times.
- N_OUT=3, sel_data=3 -> in_ack toggles without any out_req change, sel_err=1, drop_cnt=1; 300 such tokens -> drop_cnt=255.
- Assert rst while in WAIT for channel 1 -> state IDLE, out_req=PHASE_INIT_OUT, in_ack=PHASE_INIT_A; a late out_ack[1] toggle then blocks acceptance until corrected.
- With CLICK_DEMUX_SYNC_EN: same token as the second scenario -> out_req[2] toggles 3 cycles after the req edge; in_ack toggles 3 cycles after out_ack.

Source files
------------

// File: rtl/click_demux_n.sv
// N-way two-phase click demux: routes one bundled-data token plus select to one registered output channel.
// Optional build macro CLICK_DEMUX_SYNC_EN adds two-flop synchronisers on in_req, sel_req and out_ack.
module click_demux_n #(
   parameter int               N_OUT          = 4,
   parameter int               DATA_W         = 8,
   parameter int               SEL_W          = $clog2(N_OUT),
   parameter logic             PHASE_INIT_A   = 1'b0,
   parameter logic [N_OUT-1:0] PHASE_INIT_OUT = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_req,
   output logic                    in_ack,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    sel_req,
   output logic                    sel_ack,
   input  logic [SEL_W-1:0]        sel_data,
   output logic [N_OUT-1:0]        out_req,
   input  logic [N_OUT-1:0]        out_ack,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic                    sel_err,
   output logic [7:0]              drop_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam logic [SEL_W:0] N_OUT_W = N_OUT[SEL_W:0];

   state_t                    state_q, state_d;
   logic                      ack_q, ack_d;
   logic [N_OUT-1:0]          out_req_q, out_req_d;
   logic [N_OUT*DATA_W-1:0]   out_data_q, out_data_d;
   logic [SEL_W-1:0]          chan_q, chan_d;
   logic                      sel_err_q, sel_err_d;
   logic [7:0]                drop_cnt_q, drop_cnt_d;

   logic                      in_req_s;
   logic                      sel_req_s;
   logic [N_OUT-1:0]          out_ack_s;

`ifdef CLICK_DEMUX_SYNC_EN
   logic [1:0]                in_req_sync_q;
   logic [1:0]                sel_req_sync_q;
   logic [N_OUT-1:0]          out_ack_sync1_q;
   logic [N_OUT-1:0]          out_ack_sync2_q;

   // Reset to the idle phase so no token or ack appears spuriously after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_req_sync_q   <= {2{PHASE_INIT_A}};
         sel_req_sync_q  <= {2{PHASE_INIT_A}};
         out_ack_sync1_q <= PHASE_INIT_OUT;
         out_ack_sync2_q <= PHASE_INIT_OUT;
      end else begin
         in_req_sync_q   <= {in_req_sync_q[0], in_req};
         sel_req_sync_q  <= {sel_req_sync_q[0], sel_req};
         out_ack_sync1_q <= out_ack;
         out_ack_sync2_q <= out_ack_sync1_q;
      end
   end

   assign in_req_s  = in_req_sync_q[1];
   assign sel_req_s = sel_req_sync_q[1];
   assign out_ack_s = out_ack_sync2_q;
`else
   assign in_req_s  = in_req;
   assign sel_req_s = sel_req;
   assign out_ack_s = out_ack;
`endif

   logic pending;
   logic all_idle;
   logic sel_ok;

   assign pending  = (in_req_s != ack_q) && (sel_req_s != ack_q);
   assign all_idle = (out_ack_s == out_req_q);
   assign sel_ok   = ({1'b0, sel_data} < N_OUT_W);

   always_comb begin
      state_d    = state_q;
      ack_d      = ack_q;
      out_req_d  = out_req_q;
      out_data_d = out_data_q;
      chan_d     = chan_q;
      sel_err_d  = sel_err_q;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         IDLE: begin
            if (pending) begin
               if (!sel_ok) begin
                  // Bad select: consume the token without touching any output channel.
                  ack_d     = ~ack_q;
                  sel_err_d = 1'b1;
                  if (drop_cnt_q != 8'hFF) begin
                     drop_cnt_d = drop_cnt_q + 8'd1;
                  end
               end else if (all_idle) begin
                  out_data_d[sel_data*DATA_W +: DATA_W] = in_data;
                  out_req_d[sel_data] = ~out_req_q[sel_data];
                  chan_d  = sel_data;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (out_ack_s[chan_q] == out_req_q[chan_q]) begin
               ack_d   = ~ack_q;
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ack_q      <= PHASE_INIT_A;
         out_req_q  <= PHASE_INIT_OUT;
         out_data_q <= '0;
         chan_q     <= '0;
         sel_err_q  <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         out_req_q  <= out_req_d;
         out_data_q <= out_data_d;
         chan_q     <= chan_d;
         sel_err_q  <= sel_err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign in_ack   = ack_q;
   assign sel_ack  = ack_q;
   assign out_req  = out_req_q;
   assign out_data = out_data_q;
   assign sel_err  = sel_err_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_click_demux_n.sv
// Bench for click_demux_n: a 4-way instance for routing/reset cases and a 3-way instance for bad selects.
module tb_click_demux_n;

`ifdef CLICK_DEMUX_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst;

   logic        in_req, sel_req, in_ack, sel_ack;
   logic [7:0]  in_data;
   logic [1:0]  sel_data;
   logic [3:0]  out_req, out_ack;
   logic [31:0] out_data;
   logic        sel_err;
   logic [7:0]  drop_cnt;

   logic        d3_in_req, d3_sel_req, d3_in_ack, d3_sel_ack;
   logic [7:0]  d3_in_data;
   logic [1:0]  d3_sel_data;
   logic [2:0]  d3_out_req, d3_out_ack;
   logic [23:0] d3_out_data;
   logic        d3_sel_err;
   logic [7:0]  d3_drop_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   click_demux_n #(.N_OUT(4), .DATA_W(8)) u_dut4 (
      .clk(clk), .rst(rst),
      .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
      .sel_req(sel_req), .sel_ack(sel_ack), .sel_data(sel_data),
      .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
      .sel_err(sel_err), .drop_cnt(drop_cnt)
   );

   click_demux_n #(.N_OUT(3), .DATA_W(8)) u_dut3 (
      .clk(clk), .rst(rst),
      .in_req(d3_in_req), .in_ack(d3_in_ack), .in_data(d3_in_data),
      .sel_req(d3_sel_req), .sel_ack(d3_sel_ack), .sel_data(d3_sel_data),
      .out_req(d3_out_req), .out_ack(d3_out_ack), .out_data(d3_out_data),
      .sel_err(d3_sel_err), .drop_cnt(d3_drop_cnt)
   );

   typedef struct {
      logic [1:0] sel;
      logic [7:0] data;
      logic [3:0] exp_out_req;
   } vec_t;

   typedef struct {
      int         chan;
      logic [7:0] data;
   } sb_t;

   sb_t sb_q[$];

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_checks++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_req = 1'b0; sel_req = 1'b0; out_ack = 4'b0000;
      d3_in_req = 1'b0; d3_sel_req = 1'b0; d3_out_ack = 3'b000;
      step(3);
      rst = 1'b0;
      step(1);
   endtask

   // Drive one token, wait for the routed req edge, then ack it and wait for in_ack.
   task automatic send_routed(input vec_t v);
      logic [3:0] prev;
      logic       prev_ack;
      int         cyc;
      sb_t        exp;
      bit         seen;
      prev     = out_req;
      prev_ack = in_ack;
      in_data  = v.data;
      sel_data = v.sel;
      in_req   = ~in_req;
      sel_req  = ~sel_req;
      sb_q.push_back('{chan: int'(v.sel), data: v.data});
      seen = 1'b0;
      cyc  = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(1);
         cyc++;
         if (out_req != prev) seen = 1'b1;
      end
      exp = sb_q.pop_front();
      if (!seen) begin
         timeout("route_req");
      end else begin
         $display("token ch=%0d data=%02h out_req=%b latency=%0d", exp.chan, v.data, out_req, cyc);
         check("route_latency", 64'(cyc), 64'(LAT));
         check("route_onehot", 64'(out_req ^ prev), 64'(4'b0001 << exp.chan));
         check("route_data", 64'(out_data[exp.chan*8 +: 8]), 64'(exp.data));
         check("route_out_req", 64'(out_req), 64'(v.exp_out_req));
         check("ack_held", 64'(in_ack), 64'(prev_ack));
         out_ack[exp.chan] = ~out_ack[exp.chan];
         seen = 1'b0;
         cyc  = 0;
         for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            cyc++;
            if (in_ack != prev_ack) seen = 1'b1;
         end
         if (!seen) timeout("in_ack_toggle");
         else check("ack_latency", 64'(cyc), 64'(LAT));
      end
   endtask

   vec_t vecs[6];

   initial begin
      logic ack_before;
      bit   seen;

      vecs[0] = '{sel: 2'd0, data: 8'h11, exp_out_req: 4'b0001};
      vecs[1] = '{sel: 2'd1, data: 8'h22, exp_out_req: 4'b0011};
      vecs[2] = '{sel: 2'd2, data: 8'h33, exp_out_req: 4'b0111};
      vecs[3] = '{sel: 2'd3, data: 8'h44, exp_out_req: 4'b1111};
      vecs[4] = '{sel: 2'd1, data: 8'h5A, exp_out_req: 4'b1101};
      vecs[5] = '{sel: 2'd3, data: 8'hC3, exp_out_req: 4'b0101};

      in_data = 8'h00; sel_data = 2'd0;
      d3_in_data = 8'h00; d3_sel_data = 2'd0;
      do_reset();

      check("rst_in_ack", 64'(in_ack), 64'd0);
      check("rst_sel_ack", 64'(sel_ack), 64'd0);
      check("rst_out_req", 64'(out_req), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_sel_err", 64'(sel_err), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

      // Single token A5 to channel 2, ack held off for a few cycles.
      in_data = 8'hA5; sel_data = 2'd2;
      in_req = 1'b1; sel_req = 1'b1;
      step(LAT);
      check("a5_out_req", 64'(out_req), 64'(4'b0100));
      check("a5_data", 64'(out_data[23:16]), 64'h A5);
      step(3);
      check("a5_ack_held", 64'(in_ack), 64'd0);
      check("a5_out_req_stable", 64'(out_req), 64'(4'b0100));
      out_ack[2] = 1'b1;
      step(LAT - 1);
      check("a5_ack_not_early", 64'(in_ack), 64'd0);
      step(1);
      check("a5_in_ack", 64'(in_ack), 64'd1);
      check("a5_sel_ack", 64'(sel_ack), 64'd1);
      $display("token ch=2 data=a5 out_req=%b in_ack=%b", out_req, in_ack);

      // Table of routed tokens from a clean reset.
      do_reset();
      for (int i = 0; i < 6; i++) send_routed(vecs[i]);
      check("table_in_ack_even", 64'(in_ack), 64'd0);
      check("table_ch0_kept", 64'(out_data[7:0]), 64'h11);
      check("table_ch2_kept", 64'(out_data[23:16]), 64'h33);

      // Out-of-range select on the 3-way instance.
      d3_in_data = 8'hEE; d3_sel_data = 2'd3;
      d3_in_req = ~d3_in_req; d3_sel_req = ~d3_sel_req;
      step(LAT);
      check("drop_in_ack", 64'(d3_in_ack), 64'd1);
      check("drop_out_req", 64'(d3_out_req), 64'd0);
      check("drop_sel_err", 64'(d3_sel_err), 64'd1);
      check("drop_cnt_1", 64'(d3_drop_cnt), 64'd1);
      $display("drop sel=3 in_ack=%b drop_cnt=%0d", d3_in_ack, d3_drop_cnt);
      for (int t = 1; t < 300; t++) begin
         ack_before = d3_in_ack;
         d3_in_req = ~d3_in_req; d3_sel_req = ~d3_sel_req;
         seen = 1'b0;
         for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            if (d3_in_ack != ack_before) seen = 1'b1;
         end
         if (!seen) begin
            timeout("drop_loop");
            break;
         end
      end
      $display("drop x300 drop_cnt=%0d sel_err=%b", d3_drop_cnt, d3_sel_err);
      check("drop_cnt_sat", 64'(d3_drop_cnt), 64'd255);
      check("drop_sel_err_sticky", 64'(d3_sel_err), 64'd1);
      check("drop_out_data", 64'(d3_out_data), 64'd0);

      // Reset while waiting on channel 1, then a late ack blocks acceptance.
      do_reset();
      in_data = 8'h77; sel_data = 2'd1;
      in_req = 1'b1; sel_req = 1'b1;
      step(LAT);
      check("wait_out_req", 64'(out_req), 64'(4'b0010));
      rst = 1'b1;
      in_req = 1'b0; sel_req = 1'b0;
      step(1);
      rst = 1'b0;
      check("wrst_out_req", 64'(out_req), 64'd0);
      check("wrst_in_ack", 64'(in_ack), 64'd0);
      check("wrst_out_data", 64'(out_data), 64'd0);
      out_ack[1] = 1'b1;
      in_data = 8'h99; sel_data = 2'd0;
      in_req = 1'b1; sel_req = 1'b1;
      step(LAT + 4);
      check("blocked_out_req", 64'(out_req), 64'd0);
      check("blocked_in_ack", 64'(in_ack), 64'd0);
      out_ack[1] = 1'b0;
      step(LAT + LAT);
      check("unblocked_out_req", 64'(out_req), 64'(4'b0001));
      check("unblocked_data", 64'(out_data[7:0]), 64'h99);
      $display("token ch=0 data=99 out_req=%b after unblock", out_req);
      out_ack[0] = 1'b1;
      step(LAT);
      check("unblocked_in_ack", 64'(in_ack), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
